// File: rtl/intr_ctrl.sv
// intr_ctrl: machine-mode trap and interrupt controller for a single-hart core.
// Holds mstatus/mie/mip/mtvec/mepc/mcause, takes the machine timer interrupt,
// ECALL traps and MRET returns at commit, and issues a one-cycle registered
// flush/redirect to the pipeline.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   timer_irq_i        machine timer interrupt level
//   commit_valid_i     an instruction commits this cycle
//   commit_pc_i        PC of the committing instruction
//   commit_next_pc_i   PC the pipeline would fetch next
//   ecall_i, mret_i    committing instruction is ECALL / MRET
//   csr_wen_i          CSR write strobe
//   csr_addr_i         CSR address (read and write)
//   csr_wdata_i        CSR write data
//   csr_rdata_o        CSR read data, combinational from csr_addr_i
//   trap_flush_o       flush/redirect pulse, high while the FSM is in FLUSH
//   trap_pc_o          redirect target, valid while trap_flush_o=1
//   irq_taken_o        pulse with trap_flush_o when an interrupt was taken
//
// state  | meaning
// IDLE   | evaluating commits for interrupt / ECALL / MRET
// FLUSH  | redirect issued this cycle, commit inputs ignored
module intr_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_irq_i,
  input  logic        commit_valid_i,
  input  logic [63:0] commit_pc_i,
  input  logic [63:0] commit_next_pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        csr_wen_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  output logic [63:0] csr_rdata_o,
  output logic        trap_flush_o,
  output logic [63:0] trap_pc_o,
  output logic        irq_taken_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  localparam logic [63:0] CAUSE_MTI   = {1'b1, 63'd7};
  localparam logic [63:0] CAUSE_ECALL = 64'd11;

  logic [0:0]  state_q, state_d;
  logic        mie_q, mie_d;       // mstatus.MIE
  logic        mpie_q, mpie_d;     // mstatus.MPIE
  logic        mtie_q, mtie_d;     // mie.MTIE
  logic        mtip_q, mtip_d;     // mip.MTIP
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] trap_pc_q, trap_pc_d;
  logic        irq_taken_q, irq_taken_d;

  logic        in_idle;
  logic        take_irq;
  logic        do_ecall;
  logic        do_mret;

  // CSR read mux; MPP is hardwired to machine mode.
  always_comb begin
    csr_rdata_o = 64'd0;
    case (csr_addr_i)
      A_MSTATUS: csr_rdata_o = {51'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      A_MIE:     csr_rdata_o = {56'd0, mtie_q, 7'd0};
      A_MTVEC:   csr_rdata_o = mtvec_q;
      A_MEPC:    csr_rdata_o = mepc_q;
      A_MCAUSE:  csr_rdata_o = mcause_q;
      A_MIP:     csr_rdata_o = {56'd0, mtip_q, 7'd0};
      default:   csr_rdata_o = 64'd0;
    endcase
  end

  assign in_idle  = (state_q == S_IDLE);
  assign take_irq = in_idle & commit_valid_i & mie_q & mtie_q & mtip_q;
  assign do_ecall = in_idle & commit_valid_i & ecall_i & ~take_irq;
  assign do_mret  = in_idle & commit_valid_i & mret_i & ~take_irq & ~ecall_i;

  always_comb begin
    state_d     = S_IDLE;
    mie_d       = mie_q;
    mpie_d      = mpie_q;
    mtie_d      = mtie_q;
    mtip_d      = timer_irq_i;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    trap_pc_d   = trap_pc_q;
    irq_taken_d = 1'b0;

    // Software CSR writes go first so a same-cycle trap/mret update below
    // overrides only the fields it owns.
    if (csr_wen_i) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          mie_d  = csr_wdata_i[3];
          mpie_d = csr_wdata_i[7];
        end
        A_MIE:    mtie_d   = csr_wdata_i[7];
        A_MTVEC:  mtvec_d  = {csr_wdata_i[63:2], 2'b00};
        A_MEPC:   mepc_d   = {csr_wdata_i[63:2], 2'b00};
        A_MCAUSE: mcause_d = csr_wdata_i;
        default: ;
      endcase
    end

    if (take_irq) begin
      mepc_d      = commit_next_pc_i;
      mcause_d    = CAUSE_MTI;
      mpie_d      = mie_q;
      mie_d       = 1'b0;
      trap_pc_d   = mtvec_q;
      irq_taken_d = 1'b1;
      state_d     = S_FLUSH;
    end else if (do_ecall) begin
      mepc_d    = commit_pc_i;
      mcause_d  = CAUSE_ECALL;
      mpie_d    = mie_q;
      mie_d     = 1'b0;
      trap_pc_d = mtvec_q;
      state_d   = S_FLUSH;
    end else if (do_mret) begin
      mie_d     = mpie_q;
      mpie_d    = 1'b1;
      trap_pc_d = mepc_q;
      state_d   = S_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      mtie_q      <= 1'b0;
      mtip_q      <= 1'b0;
      mtvec_q     <= 64'd0;
      mepc_q      <= 64'd0;
      mcause_q    <= 64'd0;
      trap_pc_q   <= 64'd0;
      irq_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      mtie_q      <= mtie_d;
      mtip_q      <= mtip_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      trap_pc_q   <= trap_pc_d;
      irq_taken_q <= irq_taken_d;
    end
  end

  assign trap_flush_o = (state_q == S_FLUSH);
  assign trap_pc_o    = trap_pc_q;
  assign irq_taken_o  = irq_taken_q;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_irq_i;
  logic        commit_valid_i;
  logic [63:0] commit_pc_i;
  logic [63:0] commit_next_pc_i;
  logic        ecall_i;
  logic        mret_i;
  logic        csr_wen_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic [63:0] csr_rdata_o;
  logic        trap_flush_o;
  logic [63:0] trap_pc_o;
  logic        irq_taken_o;

  intr_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .timer_irq_i      (timer_irq_i),
    .commit_valid_i   (commit_valid_i),
    .commit_pc_i      (commit_pc_i),
    .commit_next_pc_i (commit_next_pc_i),
    .ecall_i          (ecall_i),
    .mret_i           (mret_i),
    .csr_wen_i        (csr_wen_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_rdata_o      (csr_rdata_o),
    .trap_flush_o     (trap_flush_o),
    .trap_pc_o        (trap_pc_o),
    .irq_taken_o      (irq_taken_o)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [63:0] TVEC      = 64'h8000_0100;
  localparam logic [63:0] C_MTI     = 64'h8000_0000_0000_0007;

  typedef struct {
    logic        rst;
    logic        tirq;
    logic        cv;
    logic [63:0] pc;
    logic [63:0] npc;
    logic        ecall;
    logic        mret;
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic [11:0] raddr;
    logic        exp_flush;
    logic        exp_irq;
    logic [63:0] exp_tpc;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic r, logic ti, logic cv, logic [63:0] pc, logic [63:0] npc,
                              logic ec, logic mr, logic we, logic [11:0] wa, logic [63:0] wd,
                              logic [11:0] ra, logic ef, logic ei, logic [63:0] et,
                              logic [63:0] er);
    vec_t v;
    v.rst = r; v.tirq = ti; v.cv = cv; v.pc = pc; v.npc = npc;
    v.ecall = ec; v.mret = mr; v.wen = we; v.waddr = wa; v.wdata = wd;
    v.raddr = ra; v.exp_flush = ef; v.exp_irq = ei; v.exp_tpc = et; v.exp_rdata = er;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%h expected 0x%h", name, idx, act, exp);
    end
  endtask

  // One clock: drive at negedge, check registered outputs just after the
  // rising edge, then switch the address to the read target and check rdata.
  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    rst              = v.rst;
    timer_irq_i      = v.tirq;
    commit_valid_i   = v.cv;
    commit_pc_i      = v.pc;
    commit_next_pc_i = v.npc;
    ecall_i          = v.ecall;
    mret_i           = v.mret;
    csr_wen_i        = v.wen;
    csr_addr_i       = v.waddr;
    csr_wdata_i      = v.wdata;
    @(posedge clk);
    #1;
    check("trap_flush", idx, {63'd0, trap_flush_o}, {63'd0, v.exp_flush});
    check("irq_taken",  idx, {63'd0, irq_taken_o},  {63'd0, v.exp_irq});
    check("trap_pc",    idx, trap_pc_o, v.exp_tpc);
    csr_wen_i      = 1'b0;
    commit_valid_i = 1'b0;
    csr_addr_i     = v.raddr;
    #1;
    check("csr_rdata",  idx, csr_rdata_o, v.exp_rdata);
  endtask

  initial begin
    rst = 1'b1; timer_irq_i = 1'b0; commit_valid_i = 1'b0;
    commit_pc_i = '0; commit_next_pc_i = '0; ecall_i = 1'b0; mret_i = 1'b0;
    csr_wen_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0;

    //          rst ti cv pc            npc           ec mr we waddr      wdata             raddr      fl ir tpc           rdata
    vecs.push_back(mk(1, 0, 0, 0,            0,            0, 0, 0, 0,         0,                A_MSTATUS, 0, 0, 0,            64'h1800));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 1, A_MTVEC,   64'h8000_0103,    A_MTVEC,   0, 0, 0,            TVEC));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 1, A_MSTATUS, 64'h8,            A_MSTATUS, 0, 0, 0,            64'h1808));
    vecs.push_back(mk(0, 1, 0, 0,            0,            0, 0, 1, A_MIE,     64'h80,           A_MIP,     0, 0, 0,            64'h80));
    // timer trap
    vecs.push_back(mk(0, 1, 1, 64'h8000_0010, 64'h8000_0014, 0, 0, 0, 0,       0,                A_MEPC,    1, 1, TVEC,         64'h8000_0014));
    // commit + ecall during FLUSH are ignored
    vecs.push_back(mk(0, 1, 1, 64'h8000_0018, 64'h8000_001c, 1, 0, 0, 0,       0,                A_MSTATUS, 0, 0, TVEC,         64'h1880));
    vecs.push_back(mk(0, 1, 0, 0,            0,            0, 0, 0, 0,         0,                A_MCAUSE,  0, 0, TVEC,         C_MTI));
    // MIE=0 masks the pending interrupt
    vecs.push_back(mk(0, 1, 1, 64'h8000_0014, 64'h8000_0018, 0, 0, 0, 0,       0,                A_MIP,     0, 0, TVEC,         64'h80));
    // mret returns to mepc, restores MIE
    vecs.push_back(mk(0, 1, 1, 64'h8000_0200, 64'h8000_0204, 0, 1, 0, 0,       0,                A_MSTATUS, 1, 0, 64'h8000_0014, 64'h1888));
    vecs.push_back(mk(0, 1, 1, 64'h8000_0014, 64'h8000_0018, 0, 0, 0, 0,       0,                A_MSTATUS, 0, 0, 64'h8000_0014, 64'h1888));
    // back-to-back irq, beats ecall, beats concurrent mepc write
    vecs.push_back(mk(0, 1, 1, 64'h8000_0020, 64'h8000_0024, 1, 0, 1, A_MEPC,  64'h1234,         A_MEPC,    1, 1, TVEC,         64'h8000_0024));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0, 0,         0,                A_MCAUSE,  0, 0, TVEC,         C_MTI));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0, 0,         0,                A_MSTATUS, 0, 0, TVEC,         64'h1880));
    // ECALL
    vecs.push_back(mk(0, 0, 1, 64'h8000_0040, 64'h8000_0044, 1, 0, 0, 0,       0,                A_MEPC,    1, 0, TVEC,         64'h8000_0040));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0, 0,         0,                A_MCAUSE,  0, 0, TVEC,         64'd11));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 1, A_MSTATUS, 64'h80,           A_MSTATUS, 0, 0, TVEC,         64'h1880));
    vecs.push_back(mk(0, 0, 1, 64'h8000_0300, 64'h8000_0304, 0, 1, 0, 0,       0,                A_MSTATUS, 1, 0, 64'h8000_0040, 64'h1888));
    // unmapped address and read-only mip
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 1, 12'h7c0,   64'hffff_ffff_ffff_ffff, 12'h7c0, 0, 0, 64'h8000_0040, 64'd0));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 1, A_MIP,     64'hffff_ffff_ffff_ffff, A_MIP,   0, 0, 64'h8000_0040, 64'd0));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 1, A_MEPC,    64'h0000_0000_0000_1237, A_MEPC,  0, 0, 64'h8000_0040, 64'h1234));
    // reset in the middle of FLUSH
    vecs.push_back(mk(0, 1, 0, 0,            0,            0, 0, 0, 0,         0,                A_MIP,     0, 0, 64'h8000_0040, 64'h80));
    vecs.push_back(mk(0, 1, 1, 64'h8000_0050, 64'h8000_0054, 0, 0, 0, 0,       0,                A_MEPC,    1, 1, TVEC,         64'h8000_0054));
    vecs.push_back(mk(1, 1, 1, 64'h8000_0060, 64'h8000_0064, 1, 0, 1, A_MTVEC, 64'h4444,         A_MSTATUS, 0, 0, 0,            64'h1800));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0, 0,         0,                A_MTVEC,   0, 0, 0,            64'd0));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0, 0,         0,                A_MEPC,    0, 0, 0,            64'd0));
    vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0, 0,         0,                A_MCAUSE,  0, 0, 0,            64'd0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Masking sequence 1: MTIE=1, MIE=0, timer pending for 20 commits.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, A_MTVEC, TVEC,   A_MTVEC, 0, 0, 0, TVEC), 100);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 1, A_MIE,   64'h80, A_MIE,   0, 0, 0, 64'h80), 101);
    for (int i = 0; i < 20; i++)
      apply(mk(0, 1, 1, 64'h100 + 64'(4 * i), 64'h104 + 64'(4 * i), 0, 0, 0, 0, 0,
               A_MIP, 0, 0, 0, 64'h80), 200 + i);

    // Masking sequence 2: MIE=1, MTIE=0, timer pending for 20 commits.
    apply(mk(0, 1, 0, 0, 0, 0, 0, 1, A_MSTATUS, 64'h8, A_MSTATUS, 0, 0, 0, 64'h1808), 102);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 1, A_MIE,     64'h0, A_MIE,     0, 0, 0, 64'h0), 103);
    for (int i = 0; i < 20; i++)
      apply(mk(0, 1, 1, 64'h200 + 64'(4 * i), 64'h204 + 64'(4 * i), 0, 0, 0, 0, 0,
               A_MIP, 0, 0, 0, 64'h80), 300 + i);

    // Unmasking now takes the interrupt on the next commit.
    apply(mk(0, 1, 0, 0, 0, 0, 0, 1, A_MIE, 64'h80, A_MIE, 0, 0, 0, 64'h80), 104);
    apply(mk(0, 1, 1, 64'h300, 64'h304, 0, 0, 0, 0, 0, A_MEPC, 1, 1, TVEC, 64'h304), 105);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, A_MSTATUS, 0, 0, TVEC, 64'h1880), 106);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- timer_irq_i  in  1  machine timer interrupt level from the timer/compare unit
- commit_valid_i  in  1  an instruction commits this cycle
- commit_pc_i  in  64  PC of the committing instruction
- commit_next_pc_i  in  64  PC the pipeline would fetch next
- ecall_i  in  1  committing instruction is ECALL
- mret_i  in  1  committing instruction is MRET
- csr_wen_i  in  1  CSR write strobe
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  64  CSR write data
- csr_rdata_o  out  64  CSR read data, combinational from csr_addr_i
- trap_flush_o  out  1  registered pipeline flush / redirect pulse
- trap_pc_o  out  64  registered redirect target, valid while trap_flush_o=1
- irq_taken_o  out  1  registered pulse, an interrupt (not an exception) was taken

Function
REQ-003 CSRs held: mstatus (MIE bit3, MPIE bit7, MPP bits12:11 read as 2'b11, all else 0), mie (MTIE bit7 only), mip (MTIP bit7 only, read-only), mtvec, mepc, mcause.
REQ-004 Addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344; any other address reads 64'd0 and ignores writes.
REQ-005 Writes: only implemented bits change; mtvec[1:0] and mepc[1:0] forced to 0; writes to mip ignored.
REQ-006 mip.MTIP SHALL be timer_irq_i registered one cycle (1-cycle delay, level, no latching).
REQ-007 FSM states: IDLE, FLUSH. Decisions are evaluated only in IDLE with commit_valid_i=1; in FLUSH all commit inputs are ignored.
REQ-008 take_irq = IDLE & commit_valid_i & mstatus.MIE & mie.MTIE & mip.MTIP.
REQ-009 Priority: take_irq > ecall_i > mret_i; at most one action per cycle.
REQ-010 On take_irq edge: mepc<=commit_next_pc_i, mcause<={1'b1,63'd7}, MPIE<=MIE, MIE<=0, trap_pc_o<=mtvec, irq_taken_o<=1, state<=FLUSH.
REQ-011 On ecall edge: mepc<=commit_pc_i, mcause<=64'd11, MPIE<=MIE, MIE<=0, trap_pc_o<=mtvec, state<=FLUSH.
REQ-012 On mret edge: MIE<=MPIE, MPIE<=1, trap_pc_o<=mepc (pre-update value), state<=FLUSH.
REQ-013 trap_flush_o SHALL be 1 exactly in the cycle the FSM is in FLUSH (latency 1 cycle after the deciding commit); FLUSH->IDLE unconditionally next cycle.
REQ-014 Simultaneous CSR write and trap/mret update to the same CSR: trap/mret update wins; non-conflicting CSR writes still take effect.
REQ-015 irq_taken_o SHALL be a single-cycle pulse coincident with trap_flush_o for interrupt traps only.
REQ-016 Back-to-back: an interrupt still pending after MRET is eligible in the first IDLE cycle following FLUSH.

Reset
REQ-017 On rst=1: state=IDLE, all CSR storage=0 (mstatus reads 0x1800), trap_flush_o=0, trap_pc_o=0, irq_taken_o=0; reset overrides any concurrent trap, mret or CSR write, including mid-FLUSH.

Verification
REQ-018 Timer trap: mtvec=0x8000_0100, MIE=1, MTIE=1, timer_irq_i=1, commit at pc 0x8000_0010/next 0x8000_0014 -> flush next cycle, trap_pc_o=0x8000_0100, mepc=0x8000_0014, mcause=0x8000_0000_0000_0007, mstatus=0x1880, irq_taken_o=1.
REQ-019 Masking: MIE=0 or MTIE=0 with timer_irq_i=1 for 20 commits -> no flush; mip reads 0x80.
REQ-020 Priority: interrupt pending plus ecall_i on same commit -> mcause=0x8000_0000_0000_0007, mepc=commit_next_pc_i.
REQ-021 ECALL then MRET: ecall at pc 0x8000_0040 -> mepc=0x8000_0040, mcause=11; later mret -> trap_pc_o=0x8000_0040, MIE restored, MPIE=1.
REQ-022 Collision/reset: csr write mepc=0x1234 in trap cycle -> mepc=commit_next_pc_i; rst asserted during FLUSH -> next cycle trap_flush_o=0, all CSRs 0.
